// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the rv32i_cpu execution monitor.
//   INSTR_ECALL / INSTR_EBREAK : encodings that stop the monitored program
//   halt_cause_e               : reason the monitor stopped recording
//   mon_state_e                : monitor FSM states
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
    localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

    typedef enum logic [1:0] {
        HALT_NONE    = 2'b00,
        HALT_ECALL   = 2'b01,
        HALT_EBREAK  = 2'b10,
        HALT_TIMEOUT = 2'b11
    } halt_cause_e;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'b00,
        MON_RUN   = 2'b01,
        MON_DRAIN = 2'b10,
        MON_DONE  = 2'b11
    } mon_state_e;

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO holding trace records.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (empties the FIFO)
//   push_i   : write wdata_i this cycle
//   wdata_i  : record to write
//   pop_i    : remove head this cycle (ignored when empty)
//   rdata_o  : head record; zero while empty
//   full_o   : all DEPTH entries occupied
//   empty_o  : no entries
//   drop_o   : push_i could not be accepted (full with no pop)
// A push while full is accepted when a pop frees the slot in the same cycle.
// ---------------------------------------------------------------------------
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/pipeline_trace_monitor.sv
// ---------------------------------------------------------------------------
// pipeline_trace_monitor
// Per-cycle execution monitor for the N-issue rv32i_cpu. Each RUN cycle packs
// lane and pipeline status into one record pushed into a trace FIFO drained
// by a ready/valid consumer; also detects halt and keeps saturating counters.
//   clk, rst_n                 : clock / asynchronous active-low reset
//   enable                     : start monitoring (sampled in IDLE)
//   max_cycles                 : timeout limit, 0 disables
//   lane_valid, lane_instr     : EX lane status, lane i at [32*i +: 32]
//   stall, branch_taken, bubble: pipeline status flags
//   trace_valid/ready/data     : record stream
//       trace_data = {cycle, stall, branch_taken, bubble, lane_valid, lane_instr}
//   halted, halt_cause, halt_lane, halt_cycle : latched halt information
//   done                       : halted and trace FIFO drained
//   cycle/retire/stall/drop_count, overflow   : statistics
// ---------------------------------------------------------------------------
module pipeline_trace_monitor
    import rv32i_pkg::*;
#(
    parameter  int unsigned NUM_LANES  = 2,
    parameter  int unsigned CNT_W      = 32,
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned REC_W      = CNT_W + 3 + NUM_LANES + 32 * NUM_LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        max_cycles,
    input  logic [NUM_LANES-1:0]    lane_valid,
    input  logic [32*NUM_LANES-1:0] lane_instr,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic                    bubble,
    output logic                    trace_valid,
    input  logic                    trace_ready,
    output logic [REC_W-1:0]        trace_data,
    output logic                    halted,
    output logic [1:0]              halt_cause,
    output logic [1:0]              halt_lane,
    output logic [CNT_W-1:0]        halt_cycle,
    output logic                    done,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        retire_count,
    output logic [CNT_W-1:0]        stall_count,
    output logic [CNT_W-1:0]        drop_count,
    output logic                    overflow
);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] hcycle_q, hcycle_d;
    logic             halted_q, halted_d;
    halt_cause_e      cause_q, cause_d;
    logic [1:0]       lane_q, lane_d;

    logic             push;
    logic             fifo_empty, fifo_full, fifo_drop;
    logic [REC_W-1:0] record;

    logic             instr_halt;
    halt_cause_e      instr_cause;
    logic [1:0]       instr_lane;
    logic             timeout;
    logic [CNT_W-1:0] lanes_retired;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign record = {cycle_q, stall, branch_taken, bubble, lane_valid, lane_instr};

    // Lowest-index halting lane wins: later lanes are ignored once one is found.
    always_comb begin
        instr_halt    = 1'b0;
        instr_cause   = HALT_NONE;
        instr_lane    = '0;
        lanes_retired = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lanes_retired = lanes_retired + CNT_W'(lane_valid[i]);
            if (!instr_halt && lane_valid[i]) begin
                if (lane_instr[32*i +: 32] == INSTR_ECALL) begin
                    instr_halt  = 1'b1;
                    instr_cause = HALT_ECALL;
                    instr_lane  = 2'(i);
                end else if (lane_instr[32*i +: 32] == INSTR_EBREAK) begin
                    instr_halt  = 1'b1;
                    instr_cause = HALT_EBREAK;
                    instr_lane  = 2'(i);
                end
            end
        end
    end

    // Fires on the cycle whose record is the max_cycles-th one.
    assign timeout = (max_cycles != '0) && (cycle_q >= max_cycles - CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        retire_d = retire_q;
        stall_d  = stall_q;
        hcycle_d = hcycle_q;
        halted_d = halted_q;
        cause_d  = cause_q;
        lane_d   = lane_q;
        push     = 1'b0;
        drop_d   = fifo_drop ? sat_add(drop_q, CNT_W'(1)) : drop_q;

        case (state_q)
            MON_IDLE: begin
                if (enable) state_d = MON_RUN;
            end
            MON_RUN: begin
                push     = 1'b1;
                cycle_d  = sat_add(cycle_q, CNT_W'(1));
                retire_d = sat_add(retire_q, lanes_retired);
                if (stall) stall_d = sat_add(stall_q, CNT_W'(1));
                if (instr_halt || timeout) begin
                    state_d  = MON_DRAIN;
                    halted_d = 1'b1;
                    cause_d  = instr_halt ? instr_cause : HALT_TIMEOUT;
                    lane_d   = instr_halt ? instr_lane : 2'b00;
                    hcycle_d = cycle_q;
                end
            end
            MON_DRAIN: begin
                if (fifo_empty) state_d = MON_DONE;
            end
            MON_DONE: begin
                state_d = MON_DONE;
            end
            default: state_d = MON_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MON_IDLE;
            cycle_q  <= '0;
            retire_q <= '0;
            stall_q  <= '0;
            drop_q   <= '0;
            hcycle_q <= '0;
            halted_q <= 1'b0;
            cause_q  <= HALT_NONE;
            lane_q   <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
            drop_q   <= drop_d;
            hcycle_q <= hcycle_d;
            halted_q <= halted_d;
            cause_q  <= cause_d;
            lane_q   <= lane_d;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (record),
        .pop_i   (trace_valid && trace_ready),
        .rdata_o (trace_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign trace_valid  = !fifo_empty;
    assign halted       = halted_q;
    assign halt_cause   = cause_q;
    assign halt_lane    = lane_q;
    assign halt_cycle   = hcycle_q;
    assign done         = (state_q == MON_DONE);
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign stall_count  = stall_q;
    assign drop_count   = drop_q;
    assign overflow     = (drop_q != '0);

    // Full flag is implied by drop_o; kept visible for debug probing.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// ---------------------------------------------------------------------------
// tb_pipeline_trace_monitor
// Directed self-checking bench for pipeline_trace_monitor (2 lanes, 32-bit
// counters, 4-entry trace FIFO). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pipeline_trace_monitor;

  localparam int unsigned NL    = 2;
  localparam int unsigned CW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = CW + 3 + NL + 32 * NL;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [CW-1:0]    max_cycles;
  logic [NL-1:0]    lane_valid;
  logic [32*NL-1:0] lane_instr;
  logic             stall, branch_taken, bubble;
  logic             trace_valid, trace_ready;
  logic [RW-1:0]    trace_data;
  logic             halted;
  logic [1:0]       halt_cause, halt_lane;
  logic [CW-1:0]    halt_cycle;
  logic             done;
  logic [CW-1:0]    cycle_count, retire_count, stall_count, drop_count;
  logic             overflow;

  int vectors = 0;
  int miscompares = 0;
  logic [RW-1:0] got[$];
  logic [RW-1:0] exp_rec;

  pipeline_trace_monitor #(
    .NUM_LANES  (NL),
    .CNT_W      (CW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .max_cycles   (max_cycles),
    .lane_valid   (lane_valid),
    .lane_instr   (lane_instr),
    .stall        (stall),
    .branch_taken (branch_taken),
    .bubble       (bubble),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_data   (trace_data),
    .halted       (halted),
    .halt_cause   (halt_cause),
    .halt_lane    (halt_lane),
    .halt_cycle   (halt_cycle),
    .done         (done),
    .cycle_count  (cycle_count),
    .retire_count (retire_count),
    .stall_count  (stall_count),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cyc(input logic [RW-1:0] r);
    return r[RW-1 -: CW];
  endfunction

  task automatic chk(input string tag, input bit ok,
                     input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (trace_valid && trace_ready) got.push_back(trace_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    enable       = 1'b0;
    max_cycles   = '0;
    lane_valid   = '0;
    lane_instr   = '0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    bubble       = 1'b0;
    trace_ready  = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_halted",   halted === 1'b0,      halted,      1'b0);
    chk("rst_done",     done === 1'b0,        done,        1'b0);
    chk("rst_tvalid",   trace_valid === 1'b0, trace_valid, 1'b0);
    chk("rst_cycle",    cycle_count === 32'd0, cycle_count, 32'd0);
    chk("rst_drop",     drop_count === 32'd0, drop_count,  32'd0);
    chk("rst_overflow", overflow === 1'b0,    overflow,    1'b0);

    enable     = 1'b1;
    lane_valid = 2'b11;
    lane_instr = {NOP, NOP};
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      stall = (i == 1 || i == 2);
      step();
    end
    stall = 1'b0;
    chk("A_cycle",  cycle_count === 32'd5,   cycle_count,  32'd5);
    chk("A_retire", retire_count === 32'd10, retire_count, 32'd10);
    chk("A_stall",  stall_count === 32'd2,   stall_count,  32'd2);
    chk("A_npop",   got.size() == 4,         got.size(),   4);
    for (int unsigned i = 0; i < 4; i++)
      chk("A_reccyc", cyc(got[i]) === 32'(i), cyc(got[i]), 32'(i));
    chk("A_head",   cyc(trace_data) === 32'd4, cyc(trace_data), 32'd4);
    exp_rec = {32'd1, 1'b1, 1'b0, 1'b0, 2'b11, NOP, NOP};
    chk("A_rec1",   got[1] === exp_rec, got[1], exp_rec);
    chk("A_halted", halted === 1'b0, halted, 1'b0);

    do_reset();
    enable     = 1'b1;
    lane_valid = 2'b11;
    lane_instr = {NOP, NOP};
    step();
    for (int unsigned i = 0; i < 3; i++) step();
    lane_instr = {ECALL, EBREAK};
    step();
    chk("B_halted", halted === 1'b1,      halted,     1'b1);
    chk("B_cause",  halt_cause === 2'b10, halt_cause, 2'b10);
    chk("B_lane",   halt_lane === 2'b00,  halt_lane,  2'b00);
    chk("B_hcyc",   halt_cycle === 32'd3, halt_cycle, 32'd3);
    chk("B_nodone", done === 1'b0,        done,       1'b0);
    for (int unsigned k = 0; k < 20 && !done; k++) step();
    chk("B_done",   done === 1'b1,           done,         1'b1);
    chk("B_nrec",   got.size() == 4,         got.size(),   4);
    chk("B_last",   cyc(got[3]) === 32'd3,   cyc(got[3]),  32'd3);
    chk("B_cycle",  cycle_count === 32'd4,   cycle_count,  32'd4);
    chk("B_retire", retire_count === 32'd8,  retire_count, 32'd8);
    lane_instr = {ECALL, ECALL};
    step();
    step();
    chk("B_cause_hold", halt_cause === 2'b10, halt_cause, 2'b10);
    chk("B_hcyc_hold",  halt_cycle === 32'd3, halt_cycle, 32'd3);

    do_reset();
    enable     = 1'b1;
    max_cycles = 32'd8;
    lane_valid = 2'b01;
    lane_instr = {NOP, NOP};
    step();
    for (int unsigned k = 0; k < 20 && !halted; k++) step();
    chk("C_halted", halted === 1'b1,      halted,     1'b1);
    chk("C_cause",  halt_cause === 2'b11, halt_cause, 2'b11);
    chk("C_lane",   halt_lane === 2'b00,  halt_lane,  2'b00);
    chk("C_hcyc",   halt_cycle === 32'd7, halt_cycle, 32'd7);
    for (int unsigned k = 0; k < 20 && !done; k++) step();
    chk("C_done",   done === 1'b1,          done,        1'b1);
    chk("C_nrec",   got.size() == 8,        got.size(),  8);
    chk("C_first",  cyc(got[0]) === 32'd0,  cyc(got[0]), 32'd0);
    chk("C_last",   cyc(got[7]) === 32'd7,  cyc(got[7]), 32'd7);
    chk("C_cycle",  cycle_count === 32'd8,  cycle_count, 32'd8);

    do_reset();
    enable      = 1'b1;
    trace_ready = 1'b0;
    lane_valid  = 2'b01;
    lane_instr  = {NOP, NOP};
    step();
    for (int unsigned i = 0; i < 10; i++) begin
      if (i == 9) lane_instr = {NOP, EBREAK};
      step();
    end
    chk("D_drop",     drop_count === 32'd6,    drop_count,   32'd6);
    chk("D_overflow", overflow === 1'b1,       overflow,     1'b1);
    chk("D_retire",   retire_count === 32'd10, retire_count, 32'd10);
    chk("D_hcyc",     halt_cycle === 32'd9,    halt_cycle,   32'd9);
    chk("D_cause",    halt_cause === 2'b10,    halt_cause,   2'b10);
    trace_ready = 1'b1;
    for (int unsigned k = 0; k < 20 && !done; k++) step();
    chk("D_done",     done === 1'b1,   done,       1'b1);
    chk("D_nrec",     got.size() == 4, got.size(), 4);
    for (int unsigned i = 0; i < 4; i++)
      chk("D_reccyc", cyc(got[i]) === 32'(i), cyc(got[i]), 32'(i));

    do_reset();
    enable      = 1'b1;
    trace_ready = 1'b0;
    lane_valid  = 2'b11;
    lane_instr  = {NOP, NOP};
    step();
    for (int unsigned i = 0; i < 4; i++) step();
    chk("E_full_nodrop", drop_count === 32'd0, drop_count, 32'd0);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    chk("E_pp_nodrop", drop_count === 32'd0,      drop_count,      32'd0);
    chk("E_head",      cyc(trace_data) === 32'd1, cyc(trace_data), 32'd1);
    step();
    chk("E_still_full", drop_count === 32'd1, drop_count, 32'd1);

    do_reset();
    enable      = 1'b1;
    trace_ready = 1'b0;
    lane_valid  = 2'b01;
    lane_instr  = {NOP, NOP};
    step();
    step();
    step();
    lane_instr = {NOP, ECALL};
    step();
    chk("F_pre_halted", halted === 1'b1,      halted,      1'b1);
    chk("F_pre_tvalid", trace_valid === 1'b1, trace_valid, 1'b1);
    chk("F_pre_cause",  halt_cause === 2'b01, halt_cause,  2'b01);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("F_halted", halted === 1'b0,           halted,       1'b0);
    chk("F_tvalid", trace_valid === 1'b0,      trace_valid,  1'b0);
    chk("F_tdata",  trace_data === {RW{1'b0}}, trace_data,   {RW{1'b0}});
    chk("F_cause",  halt_cause === 2'b00,      halt_cause,   2'b00);
    chk("F_hcyc",   halt_cycle === 32'd0,      halt_cycle,   32'd0);
    chk("F_cycle",  cycle_count === 32'd0,     cycle_count,  32'd0);
    chk("F_retire", retire_count === 32'd0,    retire_count, 32'd0);
    chk("F_done",   done === 1'b0,             done,         1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk("F_idle_cycle",  cycle_count === 32'd0, cycle_count, 32'd0);
    chk("F_idle_tvalid", trace_valid === 1'b0,  trace_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
